seg7_scan_capture: RTL and testbench

- Receive-side counterpart of the top-level multiplexed 7-segment display port (out7 / en_out).
- Watches the scanned segment and digit-enable lines, decodes each stable digit back to a hex nibble, and reassembles the 8-digit 32-bit value the CPU is displaying.
- Used as a self-check observer in top-level simulation and as an on-chip loopback monitor. It flags illegal glyphs and illegal multi-digit enables.

---
 rtl/seg7_pkg.sv | 45 ++++
 rtl/seg7_scan_capture_if.sv | 28 ++
 rtl/seg7_stable_det.sv | 68 ++++++
 rtl/seg7_scan_capture.sv | 157 +++++++++++++++
 tb/tb_seg7_scan_capture.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions used by both the display encoder and the
// scan-capture observer, so both ends agree on glyphs by construction.
package seg7_pkg;

   localparam int SEG7_DIGITS = 8;

   // Segment bit positions within out7.
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   // Mask covering every segment line; used to flip polarity.
   localparam logic [6:0] SEG7_ALL = (7'b000_0001 << SEG_A) | (7'b000_0001 << SEG_B) |
                                     (7'b000_0001 << SEG_C) | (7'b000_0001 << SEG_D) |
                                     (7'b000_0001 << SEG_E) | (7'b000_0001 << SEG_F) |
                                     (7'b000_0001 << SEG_G);

   // Active-high glyphs for nibbles 0..F.
   localparam logic [6:0] SEG7_HEX [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   // Classification of the digit-enable word at a capture event.
   typedef enum logic [1:0] {
      SCAN_BLANK  = 2'd0,
      SCAN_SINGLE = 2'd1,
      SCAN_MULTI  = 2'd2
   } scan_kind_e;

   // Reverse lookup of an active-high glyph: returns {hit, nibble}.
   function automatic logic [4:0] seg7_decode(input logic [6:0] seg);
      logic [4:0] res;
      res = 5'b0_0000;
      for (int n = 0; n < 16; n++) begin
         res = (seg == SEG7_HEX[n]) ? {1'b1, 4'(n)} : res;
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_scan_capture_if.sv
// Scanned display lines plus the reassembled-frame results of the observer.
interface seg7_scan_capture_if import seg7_pkg::*; #(
   parameter int DIGITS = SEG7_DIGITS
);
   logic [6:0]          out7;
   logic [DIGITS-1:0]   en_out;
   logic [4*DIGITS-1:0] value;
   logic                frame_valid;
   logic                value_valid;
   logic [DIGITS-1:0]   digit_seen;
   logic                pattern_err;
   logic                enable_err;
   logic [15:0]         frame_count;

   // Display side: drives the scan lines, observes the results.
   modport master (
      output out7, en_out,
      input  value, frame_valid, value_valid, digit_seen,
             pattern_err, enable_err, frame_count
   );

   // Capture side: samples the scan lines, produces the results.
   modport slave (
      input  out7, en_out,
      output value, frame_valid, value_valid, digit_seen,
             pattern_err, enable_err, frame_count
   );
endinterface

// File: rtl/seg7_stable_det.sv
// Input register, polarity normalisation and stability counter. The capture
// strobe marks the single edge on which a dwell becomes SETTLE_CYCLES long.
module seg7_stable_det import seg7_pkg::*; #(
   parameter int DIGITS         = SEG7_DIGITS,
   parameter int SETTLE_CYCLES  = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit EN_ACTIVE_LOW  = 1'b1
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [6:0]        out7,
   input  logic [DIGITS-1:0] en_out,
   output logic [6:0]        seg_h,
   output logic [DIGITS-1:0] en_h,
   output logic              capture
);

   localparam logic [3:0]        SETTLE   = 4'(SETTLE_CYCLES);
   localparam logic [6:0]        SEG_FLIP = SEG_ACTIVE_LOW ? SEG7_ALL : 7'h00;
   localparam logic [DIGITS-1:0] EN_FLIP  = EN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

   logic [6:0]        seg_in_s;
   logic [DIGITS-1:0] en_in_s;
   logic              same_s;
   logic              capture_s;
   logic [3:0]        cnt_nx_s;
   logic [3:0]        cnt_r;
   logic [6:0]        seg_r;
   logic [DIGITS-1:0] en_r;

   // The incoming sample is compared with the one already held in the
   // register, so a pattern registered at edge k is captured at edge k+SETTLE.
   assign seg_in_s = out7 ^ SEG_FLIP;
   assign en_in_s  = en_out ^ EN_FLIP;
   assign same_s   = ({seg_in_s, en_in_s} == {seg_r, en_r});

   // Saturating dwell counter; strobe only on the S-1 -> S step.
   always_comb begin
      cnt_nx_s  = cnt_r;
      capture_s = 1'b0;
      if (!same_s) begin
         cnt_nx_s = 4'd0;
      end else if (cnt_r < SETTLE) begin
         cnt_nx_s  = cnt_r + 4'd1;
         capture_s = (cnt_r == (SETTLE - 4'd1));
      end else begin
         cnt_nx_s = cnt_r;
      end
   end

   // Sample register and dwell counter.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         seg_r <= 7'h00;
         en_r  <= {DIGITS{1'b0}};
         cnt_r <= 4'd0;
      end else begin
         seg_r <= seg_in_s;
         en_r  <= en_in_s;
         cnt_r <= cnt_nx_s;
      end
   end

   assign seg_h   = seg_r;
   assign en_h    = en_r;
   assign capture = capture_s;

endmodule

// File: rtl/seg7_scan_capture.sv
// Observer for a multiplexed 7-segment port: decodes each stable digit back
// to a nibble and publishes the reassembled value once every digit is seen.
module seg7_scan_capture import seg7_pkg::*; #(
   parameter int DIGITS         = SEG7_DIGITS,
   parameter int SETTLE_CYCLES  = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit EN_ACTIVE_LOW  = 1'b1
) (
   input  logic               Clk,
   input  logic               Reset,
   seg7_scan_capture_if.slave bus
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CW = $clog2(DIGITS + 1);

   logic [6:0]          seg_h_s;
   logic [DIGITS-1:0]   en_h_s;
   logic                capture_s;
   logic [CW-1:0]       en_cnt_s;
   logic [IW-1:0]       idx_s;
   scan_kind_e          kind_s;
   logic [4:0]          dec_s;

   logic [4*DIGITS-1:0] shadow_nx_s;
   logic [DIGITS-1:0]   seen_nx_s;
   logic [4*DIGITS-1:0] value_nx_s;
   logic                fv_nx_s;
   logic                vv_nx_s;
   logic                pe_nx_s;
   logic                ee_nx_s;
   logic [15:0]         fc_nx_s;

   logic [4*DIGITS-1:0] shadow_r;
   logic [DIGITS-1:0]   seen_r;
   logic [4*DIGITS-1:0] value_r;
   logic                fv_r;
   logic                vv_r;
   logic                pe_r;
   logic                ee_r;
   logic [15:0]         fc_r;

   seg7_stable_det #(
      .DIGITS         (DIGITS),
      .SETTLE_CYCLES  (SETTLE_CYCLES),
      .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
      .EN_ACTIVE_LOW  (EN_ACTIVE_LOW)
   ) u_stable (
      .Clk     (Clk),
      .Reset   (Reset),
      .out7    (bus.out7),
      .en_out  (bus.en_out),
      .seg_h   (seg_h_s),
      .en_h    (en_h_s),
      .capture (capture_s)
   );

   assign dec_s = seg7_decode(seg_h_s);

   // Count enabled digits and remember the index of the (last) enabled one.
   always_comb begin
      en_cnt_s = {CW{1'b0}};
      idx_s    = {IW{1'b0}};
      for (int i = 0; i < DIGITS; i++) begin
         if (en_h_s[i]) begin
            en_cnt_s = en_cnt_s + CW'(1);
            idx_s    = IW'(i);
         end else begin
            en_cnt_s = en_cnt_s;
         end
      end
   end

   // Classify the enable word: blanking, one digit, or an illegal overlap.
   always_comb begin
      if (en_cnt_s == CW'(0)) begin
         kind_s = SCAN_BLANK;
      end else if (en_cnt_s == CW'(1)) begin
         kind_s = SCAN_SINGLE;
      end else begin
         kind_s = SCAN_MULTI;
      end
   end

   // Capture-event handling: shadow update, frame completion and error pulses.
   always_comb begin
      shadow_nx_s = shadow_r;
      seen_nx_s   = seen_r;
      value_nx_s  = value_r;
      vv_nx_s     = vv_r;
      fc_nx_s     = fc_r;
      fv_nx_s     = 1'b0;
      pe_nx_s     = 1'b0;
      ee_nx_s     = 1'b0;
      if (capture_s) begin
         case (kind_s)
            SCAN_MULTI: begin
               ee_nx_s = 1'b1;
            end
            SCAN_SINGLE: begin
               if (dec_s[4]) begin
                  shadow_nx_s[{idx_s, 2'b00} +: 4] = dec_s[3:0];
                  seen_nx_s[idx_s]                 = 1'b1;
                  if (&seen_nx_s) begin
                     value_nx_s = shadow_nx_s;
                     fv_nx_s    = 1'b1;
                     vv_nx_s    = 1'b1;
                     fc_nx_s    = fc_r + 16'd1;
                     seen_nx_s  = {DIGITS{1'b0}};
                  end else begin
                     fv_nx_s = 1'b0;
                  end
               end else begin
                  pe_nx_s = 1'b1;
               end
            end
            default: begin
               fv_nx_s = 1'b0;
            end
         endcase
      end else begin
         fv_nx_s = 1'b0;
      end
   end

   // Frame state and registered outputs.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         shadow_r <= {(4*DIGITS){1'b0}};
         seen_r   <= {DIGITS{1'b0}};
         value_r  <= {(4*DIGITS){1'b0}};
         fv_r     <= 1'b0;
         vv_r     <= 1'b0;
         pe_r     <= 1'b0;
         ee_r     <= 1'b0;
         fc_r     <= 16'd0;
      end else begin
         shadow_r <= shadow_nx_s;
         seen_r   <= seen_nx_s;
         value_r  <= value_nx_s;
         fv_r     <= fv_nx_s;
         vv_r     <= vv_nx_s;
         pe_r     <= pe_nx_s;
         ee_r     <= ee_nx_s;
         fc_r     <= fc_nx_s;
      end
   end

   assign bus.value       = value_r;
   assign bus.frame_valid = fv_r;
   assign bus.value_valid = vv_r;
   assign bus.digit_seen  = seen_r;
   assign bus.pattern_err = pe_r;
   assign bus.enable_err  = ee_r;
   assign bus.frame_count = fc_r;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Bench for seg7_scan_capture: directed scans plus random traffic, compared
// every cycle against a dwell-length reference model of the observer.
module tb_seg7_scan_capture;

   localparam int DIGITS = 8;
   localparam int S      = 2;

   logic Clk = 1'b0;
   logic Reset;

   always #5 Clk = ~Clk;

   seg7_scan_capture_if #(.DIGITS(DIGITS)) bus();

   seg7_scan_capture #(
      .DIGITS         (DIGITS),
      .SETTLE_CYCLES  (S),
      .SEG_ACTIVE_LOW (1'b1),
      .EN_ACTIVE_LOW  (1'b1)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   localparam logic [6:0] GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   int checks   = 0;
   int failures = 0;
   int fv_pulses = 0;
   int pe_pulses = 0;
   int ee_pulses = 0;

   // Reference model state (what the outputs must read after each edge).
   logic [14:0] last_smp;
   int          dwell;
   logic [3:0]  m_nib [DIGITS];
   logic [7:0]  m_seen;
   logic [31:0] m_value;
   logic [15:0] m_fc;
   logic        m_fv, m_vv, m_pe, m_ee;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs that edge sampled.
   // A digit is captured when the trailing run of identical samples reaches
   // S+1 (the registered copy plus S repeats).
   task automatic model_step();
      logic [6:0] sh;
      logic [7:0] eh;
      int         sel;
      int         nib;
      sh   = ~bus.out7;
      eh   = ~bus.en_out;
      m_fv = 1'b0;
      m_pe = 1'b0;
      m_ee = 1'b0;
      if (Reset) begin
         for (int d = 0; d < DIGITS; d++) m_nib[d] = 4'h0;
         m_seen   = 8'h00;
         m_value  = 32'h0;
         m_fc     = 16'h0;
         m_vv     = 1'b0;
         last_smp = 15'h0;
         dwell    = 1;
      end else begin
         if ({sh, eh} == last_smp) dwell = (dwell < 100) ? dwell + 1 : dwell;
         else dwell = 1;
         last_smp = {sh, eh};
         if (dwell == S + 1) begin
            if ($countones(eh) > 1) begin
               m_ee = 1'b1;
            end else if ($countones(eh) == 1) begin
               sel = $clog2(eh);
               nib = -1;
               for (int k = 0; k < 16; k++) if (GLYPH[k] == sh) nib = k;
               if (nib < 0) begin
                  m_pe = 1'b1;
               end else begin
                  m_nib[sel]  = 4'(nib);
                  m_seen[sel] = 1'b1;
                  if (m_seen == 8'hFF) begin
                     for (int d = 0; d < DIGITS; d++) m_value[4*d +: 4] = m_nib[d];
                     m_fv   = 1'b1;
                     m_vv   = 1'b1;
                     m_fc   = m_fc + 16'd1;
                     m_seen = 8'h00;
                  end
               end
            end
         end
      end
   endtask

   // Compare process: inputs change only at negedge+1, so at each negedge the
   // inputs still equal what the preceding posedge sampled.
   initial begin
      forever begin
         @(negedge Clk);
         model_step();
         check("value",       bus.value,       m_value);
         check("frame_valid", bus.frame_valid, m_fv);
         check("value_valid", bus.value_valid, m_vv);
         check("digit_seen",  bus.digit_seen,  m_seen);
         check("pattern_err", bus.pattern_err, m_pe);
         check("enable_err",  bus.enable_err,  m_ee);
         check("frame_count", bus.frame_count, m_fc);
         check("flag_exclusive",
               32'(bus.frame_valid) + 32'(bus.pattern_err) + 32'(bus.enable_err) > 32'd1, 32'd0);
         if (bus.frame_valid === 1'b1) fv_pulses++;
         if (bus.pattern_err === 1'b1) pe_pulses++;
         if (bus.enable_err === 1'b1)  ee_pulses++;
      end
   end

   // Hold an active-high code and enable mask for a number of cycles.
   task automatic drive(input logic [6:0] code, input logic [7:0] mask, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         bus.out7   = ~code;
         bus.en_out = ~mask;
         @(negedge Clk);
         #1;
      end
   endtask

   task automatic show(input int digit, input logic [3:0] nib, input int hold, input int gap);
      drive(GLYPH[nib], 8'(1 << digit), hold);
      drive(7'h00, 8'h00, gap);
   endtask

   task automatic scan(input logic [31:0] val, input int hold, input int gap);
      for (int d = 0; d < DIGITS; d++) show(d, val[4*d +: 4], hold, gap);
   endtask

   task automatic do_reset(input int cycles);
      Reset = 1'b1;
      drive(7'h00, 8'h00, cycles);
      Reset = 1'b0;
   endtask

   task automatic clear_pulses();
      fv_pulses = 0;
      pe_pulses = 0;
      ee_pulses = 0;
   endtask

   initial begin
      Reset      = 1'b1;
      bus.out7   = 7'h7F;
      bus.en_out = 8'hFF;
      @(negedge Clk);
      #1;
      do_reset(2);

      // Reset state.
      check("reset_value", bus.value, 32'h0);
      check("reset_count", bus.frame_count, 32'h0);

      // First frame: digits 0..7 show 8,7,...,1.
      clear_pulses();
      scan(32'h12345678, 4, 1);
      check("t1_value", bus.value, 32'h12345678);
      check("t1_valid", bus.value_valid, 32'h1);
      check("t1_count", bus.frame_count, 32'h1);
      check("t1_pulses", fv_pulses, 32'd1);

      // Two back-to-back frames.
      do_reset(1);
      clear_pulses();
      scan(32'hDEADBEEF, 4, 1);
      check("t2_value_a", bus.value, 32'hDEADBEEF);
      check("t2_seen_a", bus.digit_seen, 32'h0);
      scan(32'h0000000F, 4, 1);
      check("t2_value_b", bus.value, 32'h0000000F);
      check("t2_count", bus.frame_count, 32'h2);
      check("t2_seen_b", bus.digit_seen, 32'h0);
      check("t2_pulses", fv_pulses, 32'd2);

      // Illegal glyph on digit 3, then recovery.
      do_reset(1);
      clear_pulses();
      show(0, 4'hA, 4, 1);
      show(1, 4'hB, 4, 1);
      show(2, 4'hC, 4, 1);
      drive(7'h49, 8'h08, 4);
      drive(7'h00, 8'h00, 1);
      check("t3_pe_pulses", pe_pulses, 32'd1);
      check("t3_seen", bus.digit_seen, 32'h07);
      check("t3_value_hold", bus.value, 32'h0);
      show(3, 4'h1, 4, 1);
      for (int d = 4; d < DIGITS; d++) show(d, 4'h0, 4, 1);
      check("t3_value", bus.value, 32'h00001CBA);
      check("t3_nib3", bus.value[15:12], 32'h1);

      // Overlapping enables, then short glitches.
      clear_pulses();
      drive(GLYPH[5], 8'h03, 4);
      drive(7'h00, 8'h00, 1);
      check("t4_ee_pulses", ee_pulses, 32'd1);
      check("t4_seen", bus.digit_seen, 32'h0);
      drive(7'h00, 8'h00, 3);
      drive(GLYPH[9], 8'h20, 1);
      drive(7'h00, 8'h00, 3);
      drive(GLYPH[9], 8'h20, 2);
      drive(7'h00, 8'h00, 3);
      check("t4_glitch_seen", bus.digit_seen, 32'h0);
      check("t4_glitch_flags", pe_pulses + ee_pulses + fv_pulses, 32'd1);

      // Reset mid-frame discards everything.
      for (int d = 0; d < 5; d++) show(d, 4'(d + 3), 4, 1);
      check("t5_partial", bus.digit_seen, 32'h1F);
      do_reset(1);
      check("t5_value", bus.value, 32'h0);
      check("t5_valid", bus.value_valid, 32'h0);
      check("t5_seen", bus.digit_seen, 32'h0);
      check("t5_count", bus.frame_count, 32'h0);
      scan(32'hCAFEF00D, 4, 1);
      check("t5_value_b", bus.value, 32'hCAFEF00D);
      check("t5_count_b", bus.frame_count, 32'h1);

      // Frame counter wrap from a preloaded 0xFFFF.
      force dut.fc_r = 16'hFFFF;
      m_fc = 16'hFFFF;
      #1;
      release dut.fc_r;
      clear_pulses();
      scan(32'h89ABCDEF, 3, 0);
      drive(7'h00, 8'h00, 2);
      check("t6_count", bus.frame_count, 32'h0);
      check("t6_pulses", fv_pulses, 32'd1);
      check("t6_value", bus.value, 32'h89ABCDEF);

      // Random traffic against the model.
      for (int n = 0; n < 150; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r <= 6) begin
            show($urandom_range(0, DIGITS - 1), 4'($urandom_range(0, 15)),
                 $urandom_range(1, 5), $urandom_range(0, 2));
         end else if (r == 7) begin
            drive(7'($urandom_range(0, 127)), 8'(1 << $urandom_range(0, DIGITS - 1)),
                  $urandom_range(1, 5));
            drive(7'h00, 8'h00, $urandom_range(0, 2));
         end else if (r == 8) begin
            drive(GLYPH[$urandom_range(0, 15)],
                  8'(1 << $urandom_range(0, 3)) | 8'(1 << $urandom_range(4, 7)),
                  $urandom_range(1, 5));
            drive(7'h00, 8'h00, $urandom_range(0, 2));
         end else begin
            scan($urandom, $urandom_range(3, 5), $urandom_range(0, 1));
         end
      end
      drive(7'h00, 8'h00, 4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
